// File: rtl/a2d_spi_resp_if.sv
// SPI pins, channel write port and frame status of the A2D responder.
// The master modport is the far end (SPI master plus channel writer); the slave modport is the responder.
interface a2d_spi_resp_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        wr_val;
    logic [2:0]  wr_ch;
    logic [11:0] wr_data;
    logic        frm_done;
    logic        frm_err;
    logic [15:0] last_cmd;

    modport master (
        output SS_n, SCLK, MOSI, wr_val, wr_ch, wr_data,
        input  MISO, frm_done, frm_err, last_cmd
    );

    modport slave (
        input  SS_n, SCLK, MOSI, wr_val, wr_ch, wr_data,
        output MISO, frm_done, frm_err, last_cmd
    );
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating the 8-channel 12-bit A2D, one-frame pipelined like the ADC128S.
// Optional feature macro A2D_RESP_AUTOINC_EN: bump the channel just read by INC_STEP per good frame.
module a2d_spi_resp #(
    parameter logic [11:0] RST_VAL  = 12'hC00,
    parameter logic [11:0] INC_STEP = 12'h010
) (
    input  logic           clk,
    input  logic           rst_n,
    a2d_spi_resp_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ss_sync_q, sclk_sync_q;
    logic [1:0]  mosi_sync_q;
    logic [15:0] shft_tx_q, shft_tx_d;
    logic [15:0] shft_rx_q, shft_rx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  prev_ch_q, prev_ch_d;
    logic [15:0] last_cmd_q, last_cmd_d;
    logic        miso_q, miso_d;
    logic        frm_done_q, frm_done_d;
    logic        frm_err_q, frm_err_d;
    logic [11:0] ch_q [8];
    logic [11:0] ch_d [8];

    logic ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;

    // Synchronizers: two flops for metastability, the third only for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            ss_sync_q   <= {ss_sync_q[1:0], bus.SS_n};
            sclk_sync_q <= {sclk_sync_q[1:0], bus.SCLK};
            mosi_sync_q <= {mosi_sync_q[0], bus.MOSI};
        end
    end

    assign ss_fall_s   =  ss_sync_q[2]   & ~ss_sync_q[1];
    assign ss_rise_s   = ~ss_sync_q[2]   &  ss_sync_q[1];
    assign sclk_rise_s = ~sclk_sync_q[2] &  sclk_sync_q[1];
    assign sclk_fall_s =  sclk_sync_q[2] & ~sclk_sync_q[1];

    // Frame state machine: next state, shift registers, frame status and MISO.
    always_comb begin
        state_d    = state_q;
        shft_tx_d  = shft_tx_q;
        shft_rx_d  = shft_rx_q;
        bit_cnt_d  = bit_cnt_q;
        prev_ch_d  = prev_ch_q;
        last_cmd_d = last_cmd_q;
        frm_done_d = 1'b0;
        frm_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall_s) begin
                    state_d   = ACTIVE;
                    shft_tx_d = {4'h0, ch_q[prev_ch_q]};
                    bit_cnt_d = 5'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    state_d = FINISH;
                end else if (sclk_rise_s) begin
                    shft_rx_d = {shft_rx_q[14:0], mosi_sync_q[1]};
                    bit_cnt_d = (bit_cnt_q == 5'd17) ? bit_cnt_q : bit_cnt_q + 5'd1;
                end else if (sclk_fall_s) begin
                    shft_tx_d = {shft_tx_q[14:0], 1'b0};
                end else begin
                    state_d = ACTIVE;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (bit_cnt_q == 5'd16) begin
                    frm_done_d = 1'b1;
                    last_cmd_d = shft_rx_q;
                    prev_ch_d  = shft_rx_q[13:11];
                end else begin
                    frm_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // MISO is registered from the next-state view so it tracks shft_tx without extra lag.
        if (state_d == ACTIVE) begin
            miso_d = shft_tx_d[15];
        end else begin
            miso_d = 1'b0;
        end
    end

    // Channel register next-state; a host write beats the auto-increment on the same channel.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ch_d[i] = ch_q[i];
        end
`ifdef A2D_RESP_AUTOINC_EN
        if ((state_q == FINISH) && (bit_cnt_q == 5'd16)) begin
            ch_d[prev_ch_q] = ch_q[prev_ch_q] + INC_STEP;
        end else begin
            ch_d[prev_ch_q] = ch_q[prev_ch_q];
        end
`endif
        if (bus.wr_val) begin
            ch_d[bus.wr_ch] = bus.wr_data;
        end else begin
            ch_d[bus.wr_ch] = ch_d[bus.wr_ch];
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shft_tx_q  <= 16'h0000;
            shft_rx_q  <= 16'h0000;
            bit_cnt_q  <= 5'd0;
            prev_ch_q  <= 3'b000;
            last_cmd_q <= 16'h0000;
            miso_q     <= 1'b0;
            frm_done_q <= 1'b0;
            frm_err_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ch_q[i] <= RST_VAL;
            end
        end else begin
            state_q    <= state_d;
            shft_tx_q  <= shft_tx_d;
            shft_rx_q  <= shft_rx_d;
            bit_cnt_q  <= bit_cnt_d;
            prev_ch_q  <= prev_ch_d;
            last_cmd_q <= last_cmd_d;
            miso_q     <= miso_d;
            frm_done_q <= frm_done_d;
            frm_err_q  <= frm_err_d;
            for (int i = 0; i < 8; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.frm_done = frm_done_q;
    assign bus.frm_err  = frm_err_q;
    assign bus.last_cmd = last_cmd_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: drives SPI frames as a mode-0 master and checks returned words/status.
module tb_a2d_spi_resp;

    localparam int PH = 5;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   done_cnt;
    int   err_cnt;

    a2d_spi_resp_if bus ();

    a2d_spi_resp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count high cycles of the status pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.frm_done) done_cnt <= done_cnt + 1;
        if (bus.frm_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic write_ch(input logic [2:0] ch, input logic [11:0] val);
        @(negedge clk);
        bus.wr_val = 1'b1; bus.wr_ch = ch; bus.wr_data = val;
        @(negedge clk);
        bus.wr_val = 1'b0;
    endtask

    task automatic clock_bits(input logic [15:0] cmd, input int nbits, inout logic [15:0] rx);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            repeat (PH) @(negedge clk);
            rx = {rx[14:0], bus.MISO};
            bus.SCLK = 1'b1;
            repeat (PH) @(negedge clk);
            bus.SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] cmd, input int nbits, input logic do_wr,
                              input logic [2:0] wch, input logic [11:0] wdat,
                              output logic [15:0] rx);
        logic [15:0] r;
        r = 16'h0000;
        @(negedge clk);
        bus.SS_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (do_wr) begin
            bus.wr_val = 1'b1; bus.wr_ch = wch; bus.wr_data = wdat;
        end
        @(negedge clk);
        bus.wr_val = 1'b0;
        repeat (PH) @(negedge clk);
        clock_bits(cmd, nbits, r);
        repeat (PH) @(negedge clk);
        bus.SS_n = 1'b1;
        repeat (12) @(negedge clk);
        rx = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bus.MISO !== 1'b0) begin
            tests_failed++; $display("FAIL reset_miso got %b exp 0", bus.MISO);
        end
        tests_run++;
        if (bus.frm_done !== 1'b0 || bus.frm_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_status got done=%b err=%b exp 0/0", bus.frm_done, bus.frm_err);
        end
        tests_run++;
        if (bus.last_cmd !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_last_cmd got %h exp 0000", bus.last_cmd);
        end
    endtask

    task automatic test_first_frame();
        logic [15:0] rx;
        int d0;
        write_ch(3'd7, 12'h777);
        d0 = done_cnt;
        send_frame(16'h3800, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0C00) begin
            tests_failed++; $display("FAIL first_miso got %h exp 0c00", rx);
        end
        tests_run++;
        if (bus.last_cmd !== 16'h3800) begin
            tests_failed++; $display("FAIL first_last_cmd got %h exp 3800", bus.last_cmd);
        end
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++; $display("FAIL first_done got %0d exp 1", done_cnt - d0);
        end
        send_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0777) begin
            tests_failed++; $display("FAIL prev_ch7_miso got %h exp 0777", rx);
        end
    endtask

    task automatic test_write_readback();
        logic [15:0] rx;
        int d0, e0;
        write_ch(3'd5, 12'hA5C);
        d0 = done_cnt; e0 = err_cnt;
        send_frame(16'h2800, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0C00) begin
            tests_failed++; $display("FAIL wr_frame1_miso got %h exp 0c00", rx);
        end
        send_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0A5C) begin
            tests_failed++; $display("FAIL wr_frame2_miso got %h exp 0a5c", rx);
        end
        tests_run++;
        if (done_cnt - d0 !== 2 || err_cnt - e0 !== 0) begin
            tests_failed++; $display("FAIL wr_status got done=%0d err=%0d exp 2/0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_frame_err();
        logic [15:0] rx;
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_frame(16'h2800, 9, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            tests_failed++; $display("FAIL short_status got err=%0d done=%0d exp 1/0", err_cnt - e0, done_cnt - d0);
        end
        tests_run++;
        if (bus.last_cmd !== 16'h0000) begin
            tests_failed++; $display("FAIL short_last_cmd got %h exp 0000", bus.last_cmd);
        end
        e0 = err_cnt;
        send_frame(16'h2800, 20, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            tests_failed++; $display("FAIL long_status got err=%0d done=%0d exp 1/0", err_cnt - e0, done_cnt - d0);
        end
        send_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0C00) begin
            tests_failed++; $display("FAIL err_prev_ch_miso got %h exp 0c00", rx);
        end
    endtask

    task automatic test_same_clk_write();
        logic [15:0] rx;
        write_ch(3'd0, 12'h123);
        send_frame(16'h0000, 16, 1'b1, 3'd0, 12'h456, rx);
        tests_run++;
        if (rx !== 16'h0123) begin
            tests_failed++; $display("FAIL samewr_old got %h exp 0123", rx);
        end
        send_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0456) begin
            tests_failed++; $display("FAIL samewr_new got %h exp 0456", rx);
        end
    endtask

    task automatic test_autoinc();
        logic [15:0] rx;
        logic [15:0] exp_v [3];
`ifdef A2D_RESP_AUTOINC_EN
        exp_v[0] = 16'h0FF8; exp_v[1] = 16'h0008; exp_v[2] = 16'h0018;
`else
        exp_v[0] = 16'h0FF8; exp_v[1] = 16'h0FF8; exp_v[2] = 16'h0FF8;
`endif
        write_ch(3'd2, 12'hFF8);
        send_frame(16'h1000, 16, 1'b0, 3'd0, 12'h000, rx);
        for (int k = 0; k < 3; k++) begin
            send_frame(16'h1000, 16, 1'b0, 3'd0, 12'h000, rx);
            tests_run++;
            if (rx !== exp_v[k]) begin
                tests_failed++; $display("FAIL autoinc_read%0d got %h exp %h", k, rx, exp_v[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] rx;
        int d0, e0;
        rx = 16'h0000;
        @(negedge clk);
        bus.SS_n = 1'b0;
        repeat (PH + 3) @(negedge clk);
        clock_bits(16'hFFFF, 7, rx);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.MISO !== 1'b0 || bus.last_cmd !== 16'h0000) begin
            tests_failed++; $display("FAIL midrst_outputs got miso=%b last_cmd=%h exp 0/0000", bus.MISO, bus.last_cmd);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        repeat (10) @(negedge clk);
        bus.SS_n = 1'b1;
        repeat (12) @(negedge clk);
        tests_run++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            tests_failed++; $display("FAIL midrst_partial got err=%0d done=%0d exp 1/0", err_cnt - e0, done_cnt - d0);
        end
        send_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, rx);
        tests_run++;
        if (rx !== 16'h0C00 || done_cnt - d0 !== 1) begin
            tests_failed++; $display("FAIL midrst_next got %h done=%0d exp 0c00/1", rx, done_cnt - d0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        rst_n        = 1'b1;
        bus.SS_n     = 1'b1;
        bus.SCLK     = 1'b0;
        bus.MOSI     = 1'b0;
        bus.wr_val   = 1'b0;
        bus.wr_ch    = 3'd0;
        bus.wr_data  = 12'h000;
        #5;
        test_reset();
        test_first_frame();
        test_write_readback();
        test_frame_err();
        test_same_clk_write();
        test_autoinc();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
